p_cacheline_adaptor: RTL

//   Responder end of the cache line interface (pmem_*). Accepts one 256-bit line read or write

---
 rtl/p_cacheline_adaptor_if.sv | 29 ++
 rtl/p_cacheline_adaptor.sv | 94 +++++++++
 2 files changed

// File: rtl/p_cacheline_adaptor_if.sv
// Cache-line (pmem_*) and burst-memory signals of the line adaptor.
// slave is the adaptor's view; master is the cache + memory side.
interface p_cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic               pmem_read;
  logic               pmem_write;
  logic [31:0]        pmem_address;
  logic [LINE_W-1:0]  pmem_wdata;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic               burst_read;
  logic               burst_write;
  logic [31:0]        burst_address;
  logic [BURST_W-1:0] burst_wdata;
  logic [BURST_W-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/p_cacheline_adaptor.sv
// Turns one cache-line read/write into a NUM_BEATS-beat burst on main memory.
//   state | meaning
//   IDLE  | waiting for pmem_read/pmem_write; write has priority
//   READ  | burst_read high, assembling beats into the line buffer
//   WRITE | burst_write high, presenting latched beats in order
//   DONE  | one-cycle pmem_resp, line buffer stable
module p_cacheline_adaptor #(
  parameter int LINE_W    = 256,
  parameter int BURST_W   = 64,
  parameter int NUM_BEATS = LINE_W / BURST_W,
  parameter int OFFSET_W  = 5,
  parameter int BEAT_W    = $clog2(NUM_BEATS)
) (
  input  logic clk,
  input  logic rst,
  p_cacheline_adaptor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t                               state;
  state_t                               state_nxt;
  logic [BEAT_W-1:0]                    beat;
  logic [31-OFFSET_W:0]                 line_addr;
  logic [NUM_BEATS-1:0][BURST_W-1:0]    wdata_q;
  logic [NUM_BEATS-1:0][BURST_W-1:0]    rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      line_addr <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.pmem_write) begin
            line_addr <= bus.pmem_address[31:OFFSET_W];
            wdata_q   <= bus.pmem_wdata;
            beat      <= '0;
          end else if (bus.pmem_read) begin
            line_addr <= bus.pmem_address[31:OFFSET_W];
            beat      <= '0;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            rdata_q[beat] <= bus.burst_rdata;
            beat          <= beat + 1'b1;
          end
        end
        WRITE: begin
          if (bus.burst_resp) beat <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.pmem_write)     state_nxt = WRITE;
        else if (bus.pmem_read) state_nxt = READ;
      end
      READ, WRITE: begin
        if (bus.burst_resp && beat == LAST_BEAT) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.burst_read    = (state == READ);
    bus.burst_write   = (state == WRITE);
    bus.pmem_resp     = (state == DONE);
    bus.burst_address = {line_addr, {OFFSET_W{1'b0}}};
    // Only drive write data while a write burst is active.
    bus.burst_wdata   = (state == WRITE) ? wdata_q[beat] : '0;
    bus.pmem_rdata    = rdata_q;
  end

endmodule
